// File: rtl/pattern_scheduler_pkg.sv
// Shared types and constants for the VGA pattern sequencer: FSM encoding,
// default parameters, counter widths and the step-size wrap helper.
package pattern_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_BLANK   = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_PATTERNS = 2;
    localparam int DEF_PAT_W        = 2;
    localparam int DEF_DWELL_FRAMES = 240;
    localparam int DEF_BLANK_FRAMES = 2;

    localparam int FRAME_CNT_W = 10;
    localparam int BLANK_CNT_W = 4;

    localparam logic [2:0] STEP_MIN = 3'd1;
    localparam logic [2:0] STEP_MAX = 3'd7;

    // Animation step cycles 1..7; zero is never a legal step.
    function automatic logic [2:0] next_step(input logic [2:0] step);
        return (step == STEP_MAX) ? STEP_MIN : step + 3'd1;
    endfunction

endpackage

// File: rtl/pattern_scheduler_btn_edge_sync.sv
// Two-flop synchronizer for an asynchronous push button followed by a
// rising-edge detector; rise is a single-cycle pulse in the clk domain.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    // sync[0], sync[1] form the synchronizer; sync[2] holds the previous level.
    logic [2:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], btn};
        end
    end

    assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/pattern_scheduler.sv
// Frame-synchronous playlist sequencer: owns pattern index, pause and step size,
// switching patterns only at frame origin and inserting blank frames afterwards.
module pattern_scheduler
    import pattern_scheduler_pkg::*;
#(
    parameter int NUM_PATTERNS = DEF_NUM_PATTERNS,
    parameter int PAT_W        = DEF_PAT_W,
    parameter int DWELL_FRAMES = DEF_DWELL_FRAMES,
    parameter int BLANK_FRAMES = DEF_BLANK_FRAMES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    input  logic             frame_origin,
    input  logic             auto_en,
    input  logic             btn_next,
    input  logic             btn_pause,
    input  logic             btn_speed,
    output logic [PAT_W-1:0] pattern_sel,
    output logic             paused,
    output logic [2:0]       step_size,
    output logic             blank,
    output logic             switched,
    output sched_state_t     fsm_state
);

    localparam logic [FRAME_CNT_W-1:0] DWELL_LAST = FRAME_CNT_W'(DWELL_FRAMES - 1);
    localparam logic [BLANK_CNT_W-1:0] BLANK_LAST = BLANK_CNT_W'(BLANK_FRAMES - 1);
    localparam logic [PAT_W-1:0]       PAT_LAST   = PAT_W'(NUM_PATTERNS - 1);

    sched_state_t           state;
    sched_state_t           state_next;
    logic                   vsync_q;
    logic                   frame_tick;
    logic                   next_rise;
    logic                   pause_rise;
    logic                   speed_rise;
    logic                   pause_req;
    logic                   speed_req;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [BLANK_CNT_W-1:0] blank_cnt;
    logic                   armed;
    logic                   counting;
    logic                   dwell_hit;
    logic                   do_switch;

    btn_edge_sync u_sync_next  (.clk(clk), .rst(rst), .btn(btn_next),  .rise(next_rise));
    btn_edge_sync u_sync_pause (.clk(clk), .rst(rst), .btn(btn_pause), .rise(pause_rise));
    btn_edge_sync u_sync_speed (.clk(clk), .rst(rst), .btn(btn_speed), .rise(speed_rise));

    assign frame_tick = vsync & ~vsync_q;
    assign counting   = auto_en & ~paused;
    assign dwell_hit  = frame_tick & counting & (frame_cnt == DWELL_LAST);
    assign blank      = (state == ST_BLANK);
    assign fsm_state  = state;

    // A next press outside RUN is simply not looked at, so presses never queue.
    always_comb begin
        state_next = state;
        do_switch  = 1'b0;
        case (state)
            ST_RUN: begin
                if (next_rise || dwell_hit) begin
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (armed && frame_origin) begin
                    do_switch  = 1'b1;
                    state_next = (BLANK_FRAMES == 0) ? ST_RUN : ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (frame_tick && (blank_cnt == BLANK_LAST)) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q     <= 1'b1;
            state       <= ST_RUN;
            frame_cnt   <= '0;
            blank_cnt   <= '0;
            armed       <= 1'b0;
            pause_req   <= 1'b0;
            speed_req   <= 1'b0;
            pattern_sel <= '0;
            paused      <= 1'b0;
            step_size   <= STEP_MIN;
            switched    <= 1'b0;
        end else begin
            vsync_q  <= vsync;
            state    <= state_next;
            switched <= do_switch;
            // Armed only once frame_origin has been seen low inside PENDING, so an
            // origin already high on entry does not trigger the switch.
            armed    <= (state == ST_PENDING) && !do_switch && (armed || !frame_origin);

            if (do_switch) begin
                pattern_sel <= (pattern_sel == PAT_LAST) ? '0 : pattern_sel + PAT_W'(1);
            end

            pause_req <= (pause_req & ~frame_tick) | pause_rise;
            if (frame_tick && pause_req) begin
                paused <= ~paused;
            end

            speed_req <= (speed_req & ~frame_tick) | speed_rise;
            if (frame_tick && speed_req) begin
                step_size <= next_step(step_size);
            end

            if (state != ST_RUN || state_next != ST_RUN) begin
                frame_cnt <= '0;
            end else if (frame_tick && counting) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end

            if (state != ST_BLANK) begin
                blank_cnt <= '0;
            end else if (frame_tick) begin
                blank_cnt <= blank_cnt + BLANK_CNT_W'(1);
            end
        end
    end

endmodule
